// File: rtl/xm_mem_stage_if.sv
// Bundle for the memory stage: upstream X/M handshake, data-memory req/ack port,
// and the registered M/W outputs with the stall counter and FSM debug state.
interface xm_mem_stage_if #(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 16
);
  // Upstream transfer happens on a rising edge where in_valid=1 and in_ready=1;
  // in_ready depends on stage state only. A memory request stays asserted with
  // stable address/data until the edge where mem_ack=1 is sampled.
  logic              in_valid;
  logic [31:0]       in_o;
  logic [31:0]       in_b;
  logic [31:0]       in_instr;
  logic              in_ready;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  logic              out_valid;
  logic [31:0]       out_o;
  logic [31:0]       out_d;
  logic [31:0]       out_instr;
  logic [CNT_W-1:0]  stall_cnt;
  logic              state_dbg;

  modport master (
    output in_valid, in_o, in_b, in_instr, mem_rdata, mem_ack,
    input  in_ready, mem_req, mem_we, mem_addr, mem_wdata,
    input  out_valid, out_o, out_d, out_instr, stall_cnt, state_dbg
  );

  modport slave (
    input  in_valid, in_o, in_b, in_instr, mem_rdata, mem_ack,
    output in_ready, mem_req, mem_we, mem_addr, mem_wdata,
    output out_valid, out_o, out_d, out_instr, stall_cnt, state_dbg
  );
endinterface

// File: rtl/xm_mem_stage.sv
// Memory stage between X/M and M/W: non-memory ops pass through in one cycle,
// lw/sw hold the pipeline in ACCESS until the data memory acknowledges.
module xm_mem_stage #(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic            clock,
  input  logic            reset,
  xm_mem_stage_if.slave   bus
);

  localparam logic [4:0] OP_LW = 5'b01000;
  localparam logic [4:0] OP_SW = 5'b00111;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t            state_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic              out_valid_q;
  logic [31:0]       out_o_q;
  logic [31:0]       out_d_q;
  logic [31:0]       out_instr_q;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [31:0]       cap_o_q;
  logic [31:0]       cap_instr_q;
  logic              cap_lw_q;

  logic [4:0] opcode;
  logic       is_lw;
  logic       is_sw;

  assign opcode = bus.in_instr[31:27];
  assign is_lw  = (opcode == OP_LW);
  assign is_sw  = (opcode == OP_SW);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      out_valid_q <= 1'b0;
      out_o_q     <= '0;
      out_d_q     <= '0;
      out_instr_q <= '0;
      stall_cnt_q <= '0;
      cap_o_q     <= '0;
      cap_instr_q <= '0;
      cap_lw_q    <= 1'b0;
    end else begin
      // Bubble by default; the branches below overwrite it when an op retires.
      out_valid_q <= 1'b0;
      out_o_q     <= '0;
      out_d_q     <= '0;
      out_instr_q <= '0;
      case (state_q)
        IDLE: begin
          if (bus.in_valid && (is_lw || is_sw)) begin
            state_q     <= ACCESS;
            mem_req_q   <= 1'b1;
            mem_we_q    <= is_sw;
            mem_addr_q  <= bus.in_o[ADDR_W-1:0];
            mem_wdata_q <= bus.in_b;
            cap_o_q     <= bus.in_o;
            cap_instr_q <= bus.in_instr;
            cap_lw_q    <= is_lw;
          end else if (bus.in_valid) begin
            out_valid_q <= 1'b1;
            out_o_q     <= bus.in_o;
            out_instr_q <= bus.in_instr;
          end
        end
        ACCESS: begin
          if (stall_cnt_q != {CNT_W{1'b1}}) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
          end
          if (bus.mem_ack) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            out_valid_q <= 1'b1;
            out_o_q     <= cap_o_q;
            out_d_q     <= cap_lw_q ? bus.mem_rdata : 32'h0;
            out_instr_q <= cap_instr_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.state_dbg = (state_q == ACCESS);
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_o     = out_o_q;
  assign bus.out_d     = out_d_q;
  assign bus.out_instr = out_instr_q;
  assign bus.stall_cnt = stall_cnt_q;

endmodule
